// File: rtl/capture_pkg.sv
// Shared types and geometry defaults for the camera capture path.
// Holds the controller state encoding and the RGB565 byte-phase encoding.
package capture_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        SYNC,
        ACTIVE
    } captureState;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } bytePhase;

endpackage

// File: rtl/cam_sync_edge.sv
// Input register stage for the camera bus plus vsync/href edge detect.
// Edges are taken between the registered copy and its one-cycle delay.
module cam_sync_edge (
    input  logic       writeClk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] camData,
    output logic       rHref,
    output logic [7:0] rData,
    output logic       vsRise,
    output logic       vsFall,
    output logic       hrefFall
);

    logic rVs;
    logic prevVs;
    logic prevHref;

    always_ff @(posedge writeClk or posedge reset) begin
        if (reset) begin
            rVs      <= 1'b0;
            rHref    <= 1'b0;
            rData    <= 8'd0;
            prevVs   <= 1'b0;
            prevHref <= 1'b0;
        end else begin
            rVs      <= vsync;
            rHref    <= href;
            rData    <= camData;
            prevVs   <= rVs;
            prevHref <= rHref;
        end
    end

    assign vsRise   = rVs & ~prevVs;
    assign vsFall   = ~rVs & prevVs;
    assign hrefFall = ~rHref & prevHref;

endmodule

// File: rtl/camera_capture_ctrl.sv
// Camera capture controller: assembles RGB565 pixels from the byte bus
// and issues frame-buffer writes with geometry and frame tracking.
module camera_capture_ctrl #(
    parameter int H_ACTIVE = capture_pkg::H_ACTIVE_DEF,
    parameter int V_ACTIVE = capture_pkg::V_ACTIVE_DEF
) (
    input  logic        writeClk,
    input  logic        reset,
    input  logic        captureEn,
    input  logic        singleShot,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  camData,
    output logic [9:0]  inX,
    output logic [8:0]  inY,
    output logic [15:0] pixelIn,
    output logic        writeEn,
    output logic        frameDone,
    output logic        busy,
    output logic        lineErr,
    output logic [7:0]  frameCount
);

    import capture_pkg::*;

    localparam logic [9:0] COL_MAX = 10'(H_ACTIVE);
    localparam logic [9:0] ROW_MAX = 10'(V_ACTIVE);

    captureState state;
    bytePhase    phase;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [7:0]  hiByte;
    logic        shotHold;

    logic        rHref;
    logic [7:0]  rData;
    logic        vsRise;
    logic        vsFall;
    logic        hrefFall;
    logic        lastRow;

    cam_sync_edge uSync (
        .writeClk (writeClk),
        .reset    (reset),
        .vsync    (vsync),
        .href     (href),
        .camData  (camData),
        .rHref    (rHref),
        .rData    (rData),
        .vsRise   (vsRise),
        .vsFall   (vsFall),
        .hrefFall (hrefFall)
    );

    assign lastRow = ({1'b0, row} + 10'd1) == ROW_MAX;
    assign busy    = (state != IDLE);

    // shotHold keeps a finished single-shot capture parked in IDLE
    // until captureEn is released, so one enable gives one frame.
    always_ff @(posedge writeClk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= PH_HI;
            col        <= 10'd0;
            row        <= 9'd0;
            hiByte     <= 8'd0;
            shotHold   <= 1'b0;
            inX        <= 10'd0;
            inY        <= 9'd0;
            pixelIn    <= 16'd0;
            writeEn    <= 1'b0;
            frameDone  <= 1'b0;
            lineErr    <= 1'b0;
            frameCount <= 8'd0;
        end else begin
            writeEn   <= 1'b0;
            frameDone <= 1'b0;
            if (!captureEn) begin
                shotHold <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (captureEn && !shotHold) begin
                        state   <= WAIT_VS;
                        lineErr <= 1'b0;
                    end
                end
                WAIT_VS: begin
                    if (!captureEn) begin
                        state <= IDLE;
                    end else if (vsRise) begin
                        state <= SYNC;
                    end
                end
                SYNC: begin
                    if (!captureEn) begin
                        state <= IDLE;
                    end else if (vsFall) begin
                        state <= ACTIVE;
                        row   <= 9'd0;
                        col   <= 10'd0;
                        phase <= PH_HI;
                    end
                end
                ACTIVE: begin
                    if (!captureEn) begin
                        state <= IDLE;
                    end else if (vsRise) begin
                        // Frame cut short by the camera.
                        frameDone  <= 1'b1;
                        frameCount <= frameCount + 8'd1;
                        lineErr    <= 1'b1;
                        if (singleShot) begin
                            state    <= IDLE;
                            shotHold <= 1'b1;
                        end else begin
                            state <= SYNC;
                        end
                    end else if (rHref) begin
                        if (phase == PH_HI) begin
                            hiByte <= rData;
                            phase  <= PH_LO;
                        end else begin
                            phase <= PH_HI;
                            if (col < COL_MAX) begin
                                writeEn <= 1'b1;
                                pixelIn <= {hiByte, rData};
                                inX     <= col;
                                inY     <= row;
                                col     <= col + 10'd1;
                            end else begin
                                lineErr <= 1'b1;
                            end
                        end
                    end else if (hrefFall) begin
                        phase <= PH_HI;
                        if (phase == PH_LO) begin
                            lineErr <= 1'b1;
                        end
                        if (col != 10'd0) begin
                            col <= 10'd0;
                            if (lastRow) begin
                                frameDone  <= 1'b1;
                                frameCount <= frameCount + 8'd1;
                                if (singleShot) begin
                                    state    <= IDLE;
                                    shotHold <= 1'b1;
                                end else begin
                                    state <= WAIT_VS;
                                end
                            end else begin
                                row <= row + 9'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Self-checking bench for camera_capture_ctrl on a reduced frame size.
// Random pixel data is scored against a per-line pixel model.
module tb_camera_capture_ctrl;

    localparam int H = 10;
    localparam int V = 6;

    logic        writeClk = 1'b0;
    logic        reset;
    logic        captureEn;
    logic        singleShot;
    logic        vsync;
    logic        href;
    logic [7:0]  camData;
    logic [9:0]  inX;
    logic [8:0]  inY;
    logic [15:0] pixelIn;
    logic        writeEn;
    logic        frameDone;
    logic        busy;
    logic        lineErr;
    logic [7:0]  frameCount;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] pix;
        int          cyc;
    } wrExp;

    wrExp expQ[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   wrCount = 0;
    int   doneCount = 0;
    int   modelRow = 0;
    int   expFrames = 0;
    bit   expErr = 1'b0;
    bit   scoreOn = 1'b1;

    camera_capture_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V)
    ) dut (
        .writeClk   (writeClk),
        .reset      (reset),
        .captureEn  (captureEn),
        .singleShot (singleShot),
        .vsync      (vsync),
        .href       (href),
        .camData    (camData),
        .inX        (inX),
        .inY        (inY),
        .pixelIn    (pixelIn),
        .writeEn    (writeEn),
        .frameDone  (frameDone),
        .busy       (busy),
        .lineErr    (lineErr),
        .frameCount (frameCount)
    );

    always #5 writeClk = ~writeClk;

    always @(posedge writeClk) cyc++;

    always @(negedge writeClk) begin : monitor
        wrExp e;
        if (writeEn) begin
            wrCount++;
            checks++;
            if (int'(inX) >= H || int'(inY) >= V || !busy) begin
                fails++;
                $display("FAIL write_bounds x=%0d y=%0d busy=%0b",
                         inX, inY, busy);
            end
            if (scoreOn) begin
                checks++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write x=%0d y=%0d pix=%h cyc=%0d",
                             inX, inY, pixelIn, cyc);
                end else begin
                    e = expQ.pop_front();
                    if (int'(inX) !== e.x || int'(inY) !== e.y ||
                        pixelIn !== e.pix || cyc !== e.cyc) begin
                        fails++;
                        $display("FAIL write got x=%0d y=%0d pix=%h cyc=%0d want x=%0d y=%0d pix=%h cyc=%0d",
                                 inX, inY, pixelIn, cyc, e.x, e.y, e.pix, e.cyc);
                    end
                end
            end
        end
        if (frameDone) doneCount++;
    end

    task automatic drive_vsync();
        @(negedge writeClk);
        vsync = 1'b1;
        repeat (3) @(negedge writeClk);
        vsync = 1'b0;
        repeat (4) @(negedge writeClk);
        modelRow = 0;
    endtask

    // One camera line of nBytes; when model is set, the expected writes
    // are queued: pixel i takes bytes 2i,2i+1 and lands 3 cycles after byte 2i.
    task automatic drive_line(input int nBytes, input bit model,
                              input bit magenta);
        logic [7:0] b[];
        int c0;
        int np;
        b = new[nBytes];
        foreach (b[j]) b[j] = 8'($urandom);
        if (magenta) begin
            b[0] = 8'hF8;
            b[1] = 8'h1F;
        end
        @(negedge writeClk);
        c0 = cyc;
        if (model) begin
            np = nBytes / 2;
            for (int i = 0; i < np && i < H; i++) begin
                expQ.push_back('{i, modelRow, {b[2*i], b[2*i+1]},
                                 c0 + 2*i + 3});
            end
            if ((nBytes % 2) != 0 || np > H) expErr = 1'b1;
            if (np > 0) modelRow++;
        end
        for (int j = 0; j < nBytes; j++) begin
            if (j > 0) @(negedge writeClk);
            href    = 1'b1;
            camData = b[j];
        end
        @(negedge writeClk);
        href    = 1'b0;
        camData = 8'($urandom);
        repeat (4) @(negedge writeClk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({inX, inY, pixelIn, writeEn, frameDone, lineErr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs x=%0d y=%0d pix=%h we=%0b fd=%0b le=%0b want 0",
                     inX, inY, pixelIn, writeEn, frameDone, lineErr);
        end
        checks++;
        if (busy !== 1'b0 || frameCount !== 8'd0) begin
            fails++;
            $display("FAIL reset_state busy=%0b fc=%0d want 0 0",
                     busy, frameCount);
        end
        repeat (3) @(negedge writeClk);
        reset = 1'b0;
        repeat (2) @(negedge writeClk);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_without_enable busy=%0b want 0", busy);
        end
    endtask

    task automatic test_full_frame();
        int d0;
        singleShot = 1'b1;
        captureEn  = 1'b1;
        repeat (3) @(negedge writeClk);
        expErr = 1'b0;
        d0 = doneCount;
        drive_vsync();
        for (int y = 0; y < V; y++) drive_line(2*H, 1'b1, y == 0);
        expFrames++;
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL full_frame_missing got %0d left want 0", expQ.size());
        end
        checks++;
        if (doneCount - d0 !== 1) begin
            fails++;
            $display("FAIL full_frame_done got %0d want 1", doneCount - d0);
        end
        checks++;
        if (frameCount !== 8'(expFrames)) begin
            fails++;
            $display("FAIL full_frame_count got %0d want %0d", frameCount, expFrames);
        end
        checks++;
        if (lineErr !== expErr) begin
            fails++;
            $display("FAIL full_frame_lineErr got %0b want %0b", lineErr, expErr);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL single_shot_idle busy=%0b want 0", busy);
        end
        checks++;
        if (inX !== 10'(H-1) || inY !== 9'(V-1)) begin
            fails++;
            $display("FAIL last_write_hold got x=%0d y=%0d want x=%0d y=%0d",
                     inX, inY, H-1, V-1);
        end
        captureEn = 1'b0;
        repeat (3) @(negedge writeClk);
    endtask

    task automatic test_long_line();
        int d0;
        singleShot = 1'b0;
        captureEn  = 1'b1;
        repeat (3) @(negedge writeClk);
        expErr = 1'b0;
        d0 = doneCount;
        drive_vsync();
        drive_line(2*H + 3, 1'b1, 1'b0);
        checks++;
        if (lineErr !== expErr) begin
            fails++;
            $display("FAIL long_line_lineErr got %0b want %0b", lineErr, expErr);
        end
        for (int y = 1; y < V; y++) begin
            drive_line(2 * int'($urandom_range(1, H)), 1'b1, 1'b0);
        end
        expFrames++;
        checks++;
        if (expQ.size() != 0 || doneCount - d0 !== 1) begin
            fails++;
            $display("FAIL long_line_frame got left=%0d done=%0d want 0 1",
                     expQ.size(), doneCount - d0);
        end
        checks++;
        if (frameCount !== 8'(expFrames) || busy !== 1'b1) begin
            fails++;
            $display("FAIL continuous_rearm got fc=%0d busy=%0b want %0d 1",
                     frameCount, busy, expFrames);
        end
    endtask

    task automatic test_early_vsync();
        int d0;
        captureEn = 1'b0;
        repeat (3) @(negedge writeClk);
        captureEn = 1'b1;
        repeat (3) @(negedge writeClk);
        expErr = 1'b0;
        checks++;
        if (lineErr !== 1'b0) begin
            fails++;
            $display("FAIL lineErr_clear got %0b want 0", lineErr);
        end
        drive_vsync();
        for (int y = 0; y < 3; y++) drive_line(2*H, 1'b1, 1'b0);
        d0 = doneCount;
        drive_vsync();
        expFrames++;
        expErr = 1'b1;
        checks++;
        if (doneCount - d0 !== 1 || lineErr !== expErr) begin
            fails++;
            $display("FAIL early_vsync got done=%0d le=%0b want 1 1",
                     doneCount - d0, lineErr);
        end
        checks++;
        if (frameCount !== 8'(expFrames)) begin
            fails++;
            $display("FAIL early_vsync_count got %0d want %0d", frameCount, expFrames);
        end
        for (int y = 0; y < V; y++) drive_line(2*H, 1'b1, 1'b0);
        expFrames++;
        checks++;
        if (expQ.size() != 0 || doneCount - d0 !== 2 ||
            frameCount !== 8'(expFrames)) begin
            fails++;
            $display("FAIL after_early_frame got left=%0d done=%0d fc=%0d want 0 2 %0d",
                     expQ.size(), doneCount - d0, frameCount, expFrames);
        end
    endtask

    task automatic test_abort();
        int w0;
        int d0;
        drive_vsync();
        for (int y = 0; y < 3; y++) drive_line(2*H, 1'b1, 1'b0);
        @(negedge writeClk);
        captureEn = 1'b0;
        @(negedge writeClk);
        w0 = wrCount;
        d0 = doneCount;
        drive_line(2*H, 1'b0, 1'b0);
        drive_line(2*H, 1'b0, 1'b0);
        checks++;
        if (wrCount !== w0 || doneCount !== d0) begin
            fails++;
            $display("FAIL abort_quiet got writes=%0d done=%0d want 0 0",
                     wrCount - w0, doneCount - d0);
        end
        checks++;
        if (frameCount !== 8'(expFrames) || busy !== 1'b0 || expQ.size() != 0) begin
            fails++;
            $display("FAIL abort_state got fc=%0d busy=%0b left=%0d want %0d 0 0",
                     frameCount, busy, expQ.size(), expFrames);
        end
    endtask

    task automatic test_reset_midline();
        int w0;
        int d0;
        captureEn  = 1'b1;
        singleShot = 1'b0;
        repeat (3) @(negedge writeClk);
        drive_vsync();
        drive_line(2*H, 1'b1, 1'b0);
        scoreOn = 1'b0;
        for (int j = 0; j < H + 1; j++) begin
            @(negedge writeClk);
            href    = 1'b1;
            camData = 8'($urandom);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({inX, inY, pixelIn, writeEn, frameDone, lineErr, busy} !== '0 ||
            frameCount !== 8'd0) begin
            fails++;
            $display("FAIL reset_midline x=%0d y=%0d pix=%h we=%0b fd=%0b le=%0b busy=%0b fc=%0d want 0",
                     inX, inY, pixelIn, writeEn, frameDone, lineErr, busy, frameCount);
        end
        expQ.delete();
        expFrames = 0;
        repeat (2) @(negedge writeClk);
        reset = 1'b0;
        scoreOn = 1'b1;
        repeat (4) @(negedge writeClk);
        href = 1'b0;
        repeat (4) @(negedge writeClk);
        w0 = wrCount;
        d0 = doneCount;
        drive_line(2*H, 1'b0, 1'b0);
        drive_line(2*H, 1'b0, 1'b0);
        checks++;
        if (wrCount !== w0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL wait_for_vsync got writes=%0d busy=%0b want 0 1",
                     wrCount - w0, busy);
        end
        expErr = 1'b0;
        drive_vsync();
        for (int y = 0; y < V; y++) drive_line(2*H, 1'b1, y == 2);
        expFrames++;
        checks++;
        if (expQ.size() != 0 || doneCount - d0 !== 1 ||
            frameCount !== 8'(expFrames)) begin
            fails++;
            $display("FAIL resume_frame got left=%0d done=%0d fc=%0d want 0 1 %0d",
                     expQ.size(), doneCount - d0, frameCount, expFrames);
        end
        checks++;
        if (wrCount - w0 !== H * V || lineErr !== expErr) begin
            fails++;
            $display("FAIL resume_writes got %0d le=%0b want %0d %0b",
                     wrCount - w0, lineErr, H * V, expErr);
        end
    endtask

    initial begin
        captureEn  = 1'b0;
        singleShot = 1'b0;
        vsync      = 1'b0;
        href       = 1'b0;
        camData    = 8'd0;
        test_reset();
        test_full_frame();
        test_long_line();
        test_early_vsync();
        test_abort();
        test_reset_midline();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/camera_capture_ctrl.md
CAMERA_CAPTURE_CTRL -- requirements
Module: camera_capture_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have port writeClk  in  1  camera pixel clock; the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port captureEn  in  1  level; high permits capture.
REQ-006 SHALL have port singleShot  in  1  level; high means stop after one frame.
REQ-007 SHALL have port vsync  in  1  camera frame sync; high between frames.
REQ-008 SHALL have port href  in  1  camera line-valid.
REQ-009 SHALL have port camData  in  8  camera byte bus.
REQ-010 SHALL have port inX  out  10  frame-buffer write column.
REQ-011 SHALL have port inY  out  9  frame-buffer write row.
REQ-012 SHALL have port pixelIn  out  16  assembled RGB565 pixel.
REQ-013 SHALL have port writeEn  out  1  one-cycle write strobe.
REQ-014 SHALL have port frameDone  out  1  one-cycle end-of-frame pulse.
REQ-015 SHALL have port busy  out  1  high in any state except IDLE.
REQ-016 SHALL have port lineErr  out  1  sticky geometry-error flag.
REQ-017 SHALL have port frameCount  out  8  completed frames, wraps 255->0.

Function
REQ-018 SHALL register vsync, href and camData once; all decisions use the registered copies (rVs, rHref, rData).
REQ-019 SHALL implement states IDLE, WAIT_VS, SYNC, ACTIVE.
REQ-020 IDLE->WAIT_VS when captureEn=1; this transition clears lineErr.
REQ-021 WAIT_VS->SYNC on rVs rising edge; SYNC->ACTIVE on rVs falling edge, with row=0, col=0, byte phase=0.
REQ-022 In ACTIVE, while rHref=1, each cycle SHALL alternate byte phase: phase 0 latches rData as pixel[15:8]; phase 1 forms pixel[7:0].
REQ-023 On the cycle after a phase-1 byte, SHALL drive pixelIn, inX=col and inY=row with writeEn=1 for exactly one cycle, then increment col.
REQ-024 Pixels with col>=H_ACTIVE SHALL produce no writeEn and SHALL set lineErr.
REQ-025 On rHref falling edge with col>0, SHALL increment row, clear col and phase; an odd byte count SHALL discard the partial byte and set lineErr.
REQ-026 When row reaches V_ACTIVE, SHALL pulse frameDone for one cycle and increment frameCount.
REQ-027 A rVs rising edge in ACTIVE with row<V_ACTIVE SHALL pulse frameDone, increment frameCount, set lineErr, and go to SYNC (continuous) or IDLE (singleShot).
REQ-028 After a complete frame, SHALL go to IDLE if singleShot=1 or captureEn=0, else to WAIT_VS.
REQ-029 captureEn falling in WAIT_VS, SYNC or ACTIVE SHALL abort to IDLE next cycle, with no frameDone and no further writeEn.
REQ-030 writeEn SHALL never be high outside ACTIVE, and never with inX>=H_ACTIVE or inY>=V_ACTIVE.
REQ-031 inX and inY SHALL hold their last values when writeEn=0.

Reset
REQ-032 Asserting reset SHALL immediately force state=IDLE and all outputs, counters, phase and input registers to 0.
REQ-033 Reset asserted mid-frame SHALL cancel any pending writeEn and frameDone, and SHALL NOT increment frameCount.

Structure
REQ-034 SHALL place the state enum, H_ACTIVE/V_ACTIVE defaults and the byte-phase encoding in shared package capture_pkg.
REQ-035 SHALL place the input register stage plus rising/falling edge detect of vsync/href in one sub-module cam_sync_edge.

Verification
REQ-036 Stimulus: 640x480 frame, 1280 bytes per line, captureEn=1, singleShot=1 -> 307200 writeEn pulses, last write at inX=639, inY=479; one frameDone; frameCount=1; then IDLE with busy=0.
REQ-037 Stimulus: bytes 0xF8 then 0x1F -> pixelIn=0xF81F with writeEn high one cycle after the second byte is registered.
REQ-038 Stimulus: a line of 1283 bytes -> 640 writes on that line; lineErr=1; next line starts at inX=0 with inY incremented.
REQ-039 Stimulus: vsync rises after 100 lines -> frameDone pulse, lineErr=1, frameCount increments; next frame begins at inY=0.
REQ-040 Stimulus: captureEn dropped at row 200 -> no writeEn from the next cycle, no frameDone, frameCount unchanged.
REQ-041 Stimulus: reset pulsed mid-line -> all outputs 0 within the same cycle; capture resumes only after the next full vsync pulse.
